// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: LSU state encoding, func3 codes and the func3 legality helper.
// Define LSU_SUBWORD_EN to enable byte/half accesses; otherwise only LW/SW are legal.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone,
    StFault
  } lsu_state_t;

  function automatic logic func3_legal(input logic [2:0] f3, input logic is_store);
`ifdef LSU_SUBWORD_EN
    if (is_store) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
`else
    return f3 == (is_store ? F3_SW : F3_LW);
`endif
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store replication, load extension, alignment.
// Sub-word handling exists only when LSU_SUBWORD_EN is defined.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]      func3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            misaligned
);

`ifdef LSU_SUBWORD_EN
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane  = bus_rdata[8*addr_lo +: 8];
    half_lane  = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    be         = 4'b1111;
    wdata      = store_data;
    rdata      = bus_rdata;
    misaligned = 1'b0;
    // func3[1:0] encodes the access size for both loads and stores.
    unique case (func3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
    case (func3)
      F3_LB:   rdata = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  rdata = {24'h0, byte_lane};
      F3_LH:   rdata = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  rdata = {16'h0, half_lane};
      default: rdata = bus_rdata;
    endcase
  end
`else
  logic unused_func3;
  assign unused_func3 = ^func3;
  assign be           = 4'b1111;
  assign wdata        = store_data;
  assign rdata        = bus_rdata;
  assign misaligned   = (addr_lo != 2'b00);
`endif

endmodule

// File: rtl/lsu_controller.sv
// Multi-cycle load/store sequencer driving a ready-handshaked data bus with timeout faulting.
// Sub-word accesses are enabled by defining LSU_SUBWORD_EN.
module lsu_controller
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid,
  output logic            fault,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_ready,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_rdata;
  logic            al_misaligned;
  logic            access_ok;

  lsu_align u_align (
    .func3      (func3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .bus_rdata  (bus_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .rdata      (al_rdata),
    .misaligned (al_misaligned)
  );

  assign access_ok = (mem_read ^ mem_write) && func3_legal(func3, mem_write) && !al_misaligned;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (mem_read || mem_write) begin
          state_d = access_ok ? StReq : StFault;
        end
      end
      StReq: begin
        // A ready arriving on the last allowed cycle still completes the access.
        if (bus_ready) begin
          state_d = StDone;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign stall = ((state_q == StIdle) && (mem_read || mem_write)) || (state_q == StReq);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_be     <= 4'b0000;
      load_data  <= '0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_req    <= (state_d == StReq);
      fault      <= (state_d == StFault);
      load_valid <= (state_q == StReq) && bus_ready && !bus_we;
      if ((state_q == StIdle) && (state_d == StReq)) begin
        bus_we    <= mem_write;
        bus_addr  <= {addr[XLEN-1:2], 2'b00};
        bus_wdata <= al_wdata;
        bus_be    <= al_be;
      end
      if ((state_q == StReq) && bus_ready) begin
        load_data <= al_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: directed accesses push expected bus/load/fault events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_controller;

`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  localparam int KReq = 0, KLoad = 1, KFault = 2;

  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_w;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, bus_ready;
  logic [2:0]  func3;
  logic [31:0] addr, store_data, bus_rdata;
  logic        stall, load_valid, fault, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .func3      (func3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .fault      (fault),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic chk_w);
    exp_t e;
    e = '{kind: KReq, we: we, addr: a, wdata: wd, be: be, chk_w: chk_w, data: 32'h0};
    q.push_back(e);
  endtask

  task automatic push_load(input logic [31:0] d);
    exp_t e;
    e = '{kind: KLoad, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0, chk_w: 1'b0, data: d};
    q.push_back(e);
  endtask

  task automatic push_fault();
    exp_t e;
    e = '{kind: KFault, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0, chk_w: 1'b0, data: 32'h0};
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per presented event and checks bus stability during REQ.
  initial begin
    logic        prev_req;
    logic        c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    exp_t        e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req && !prev_req) begin
        c_we = bus_we; c_addr = bus_addr; c_wdata = bus_wdata; c_be = bus_be;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req act=%h exp=none", bus_addr);
        end else begin
          e = q.pop_front();
          chk("req_kind", 32'(KReq), 32'(e.kind));
          chk("req_we", 32'(bus_we), 32'(e.we));
          chk("req_addr", bus_addr, e.addr);
          chk("req_be", 32'(bus_be), 32'(e.be));
          if (e.chk_w) chk("req_wdata", bus_wdata, e.wdata);
        end
      end else if (bus_req) begin
        chk("req_stable", {bus_addr[31:2], bus_we, bus_be[0]} ^ 32'(bus_be) ^ bus_wdata,
            {c_addr[31:2], c_we, c_be[0]} ^ 32'(c_be) ^ c_wdata);
      end
      prev_req = bus_req;
      if (load_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load act=%h exp=none", load_data);
        end else begin
          e = q.pop_front();
          chk("load_kind", 32'(KLoad), 32'(e.kind));
          chk("load_data", load_data, e.data);
        end
      end
      if (fault) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fault act=1 exp=none");
        end else begin
          e = q.pop_front();
          chk("fault_kind", 32'(KFault), 32'(e.kind));
        end
      end
    end
  end

  // Drives one access, answering the bus after 'waits' REQ cycles; counts stall and req cycles.
  task automatic run(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                     input int waits, input int exp_stalls, input int exp_reqs);
    int  stalls, reqs;
    bit  ended;
    stalls = 0; reqs = 0; ended = 0;
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; store_data = sd;
    bus_rdata = rdat; bus_ready = 1'b0;
    for (int c = 0; c < 300 && !ended; c++) begin
      bus_ready = bus_req && (reqs == waits);
      @(negedge clk);
      if (stall) stalls++;
      if (bus_req) reqs++;
      if (!stall) ended = 1;
      @(posedge clk);
      #1;
      bus_ready = 1'b0;
      if (ended) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    if (!ended) begin
      checks++; errors++;
      $display("FAIL %s_timeout act=running exp=ended", name);
    end
    chk({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    chk({name, "_reqs"}, 32'(reqs), 32'(exp_reqs));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=hung exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b0; addr = '0;
    store_data = '0; bus_ready = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {bus_req, bus_we, load_valid, fault, stall, bus_be}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    push_req(1'b1, 32'h104, 32'hDEADBEEF, 4'hF, 1'b1);
    run("sw", 0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 2, 1);

    if (SUB) begin push_req(1'b0, 32'h200, 32'h0, 4'h8, 1'b0); push_load(32'hFFFFFF80); end
    else push_fault();
    run("lb", 1, 0, 3'b000, 32'h203, 32'h0, 32'h80123456, 3, SUB ? 5 : 1, SUB ? 4 : 0);

    if (SUB) begin push_req(1'b0, 32'h200, 32'h0, 4'hC, 1'b0); push_load(32'h0000BEEF); end
    else push_fault();
    run("lhu", 1, 0, 3'b101, 32'h202, 32'h0, 32'hBEEF1234, 0, SUB ? 2 : 1, SUB ? 1 : 0);

    push_fault();
    run("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1, 0);

    push_req(1'b0, 32'h300, 32'h0, 4'hF, 1'b0); push_fault();
    run("tmo", 1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 1000, 5, 4);

    push_req(1'b0, 32'h400, 32'h0, 4'hF, 1'b0); push_load(32'h12345678);
    run("lw", 1, 0, 3'b010, 32'h400, 32'h0, 32'h12345678, 1, 3, 2);

    push_fault();
    run("rdwr", 1, 1, 3'b010, 32'h404, 32'h0, 32'h0, 0, 1, 0);

    push_fault();
    run("ill_ld", 1, 0, 3'b011, 32'h408, 32'h0, 32'h0, 0, 1, 0);

    push_fault();
    run("ill_st", 0, 1, 3'b100, 32'h408, 32'h0, 32'h0, 0, 1, 0);

    push_fault();
    run("sw_mis", 0, 1, 3'b010, 32'h10A, 32'h0, 32'h0, 0, 1, 0);

    if (SUB) push_req(1'b1, 32'h100, 32'hA5A5A5A5, 4'h2, 1'b1);
    else push_fault();
    run("sb", 0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 0, SUB ? 2 : 1, SUB ? 1 : 0);

    if (SUB) push_req(1'b1, 32'h104, 32'hCAFECAFE, 4'hC, 1'b1);
    else push_fault();
    run("sh", 0, 1, 3'b001, 32'h106, 32'h1234CAFE, 32'h0, 0, SUB ? 2 : 1, SUB ? 1 : 0);

    if (SUB) begin push_req(1'b0, 32'h204, 32'h0, 4'hC, 1'b0); push_load(32'hFFFF8001); end
    else push_fault();
    run("lh", 1, 0, 3'b001, 32'h206, 32'h0, 32'h80017777, 0, SUB ? 2 : 1, SUB ? 1 : 0);

    if (SUB) begin push_req(1'b0, 32'h200, 32'h0, 4'h2, 1'b0); push_load(32'h000000F0); end
    else push_fault();
    run("lbu", 1, 0, 3'b100, 32'h201, 32'h0, 32'h0000F000, 0, SUB ? 2 : 1, SUB ? 1 : 0);

    // Reset during the second REQ cycle abandons the transaction.
    push_req(1'b0, 32'h500, 32'h0, 4'hF, 1'b0);
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h500; bus_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_req_before", 32'(bus_req), 32'h1);
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_req_busreq", 32'(bus_req), 32'h0);
    chk("rst_mid_req_lv", 32'(load_valid), 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
